// File: rtl/serial_rb_sub.sv
// Bit-serial ripple-borrow subtractor: diff = x - y - bin, one bit per clock, LSB first.
// Optional signed-overflow output ovf is present when SUB_OVF_EN is defined.
module serial_rb_sub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state, state_d;
    logic [WIDTH-1:0] xq, xq_d, yq, yq_d;
    logic [WIDTH-1:0] acc, acc_d, diff_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             br, br_d;
    logic             bout_d, done_d, ready_d;
    logic             xi, yi, di, br_n;

    // Single full-subtractor cell operating on bit cnt of the latched operands
    assign xi   = xq[cnt];
    assign yi   = yq[cnt];
    assign di   = xi ^ yi ^ br;
    assign br_n = (~xi & yi) | (~(xi ^ yi) & br);

`ifdef SUB_OVF_EN
    logic ovf_d;
`endif

    always_comb begin
        state_d = state;
        xq_d    = xq;
        yq_d    = yq;
        acc_d   = acc;
        cnt_d   = cnt;
        br_d    = br;
        diff_d  = diff;
        bout_d  = bout;
        done_d  = 1'b0;
`ifdef SUB_OVF_EN
        ovf_d   = ovf;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    xq_d    = x;
                    yq_d    = y;
                    br_d    = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = {di, acc[WIDTH-1:1]};
                br_d  = br_n;
                cnt_d = cnt + CNT_W'(1);
                // Visible result only changes on the final bit
                if (cnt == LAST_BIT) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    diff_d  = acc_d;
                    bout_d  = br_n;
`ifdef SUB_OVF_EN
                    ovf_d   = (xq[WIDTH-1] != yq[WIDTH-1]) & (di != xq[WIDTH-1]);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            xq    <= '0;
            yq    <= '0;
            acc   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b1;
`ifdef SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            xq    <= xq_d;
            yq    <= yq_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            br    <= br_d;
            diff  <= diff_d;
            bout  <= bout_d;
            done  <= done_d;
            ready <= ready_d;
`ifdef SUB_OVF_EN
            ovf   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_rb_sub.sv
// Self-checking bench for serial_rb_sub: directed boundary cases plus random operands
// compared against arithmetic computed directly from x - y - bin.
module tb_serial_rb_sub;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bin;
    logic         ready;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prev_diff = '0;

    serial_rb_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .diff  (diff),
`ifdef SUB_OVF_EN
        .bout  (bout),
        .ovf   (ovf)
`else
        .bout  (bout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic logic [W-1:0] ref_diff(input int a, input int b, input int c);
        int r;
        r = a - b - c;
        return W'(r);
    endfunction

    function automatic logic ref_bout(input int a, input int b, input int c);
        return (a - b - c) < 0;
    endfunction

    function automatic logic ref_ovf(input int a, input int b, input int c);
        int sa, sb, sr;
        sa = (a >= 2**(W-1)) ? a - 2**W : a;
        sb = (b >= 2**(W-1)) ? b - 2**W : b;
        sr = sa - sb - c;
        return (sr < -(2**(W-1))) || (sr > 2**(W-1) - 1);
    endfunction

    task automatic check_result(input string tag, input int a, input int b, input int c);
        chk({tag, "_diff"}, 32'(diff), 32'(ref_diff(a, b, c)));
        chk({tag, "_bout"}, 32'(bout), 32'(ref_bout(a, b, c)));
`ifdef SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(a, b, c)));
`endif
    endtask

    // One full operation: accept, check hold during shift, latency, result, return to idle
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int lat;
        logic held;
        @(negedge clk);
        start = 1'b1; x = a; y = b; bin = c;
        @(posedge clk); #1;
        start = 1'b0;
        x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
        chk({tag, "_ready_low"}, 32'(ready), 32'd0);
        lat = 0;
        held = 1'b1;
        while (!done && lat <= 3 * W) begin
            if (diff !== prev_diff) held = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_hold"}, 32'(held), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(W));
        check_result(tag, int'(a), int'(b), int'(c));
        prev_diff = ref_diff(int'(a), int'(b), int'(c));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int ndone;
        int done_at;
        int last_done;
        int cyc;
        int n;
        logic [W-1:0] ra, rb;
        logic rc;
        logic [W-1:0] got;

        rst_n = 1'b0; start = 1'b0; x = '0; y = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
`ifdef SUB_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_op("d9m3", 4'd9, 4'd3, 1'b0);
        run_op("d3m9", 4'd3, 4'd9, 1'b0);
        run_op("zero_bin", 4'd0, 4'd0, 1'b1);
        run_op("equal", 4'd11, 4'd11, 1'b0);
        run_op("ovf_pos", 4'h7, 4'hF, 1'b0);
        run_op("ovf_neg", 4'h8, 4'h1, 1'b0);
        run_op("no_ovf", 4'd5, 4'd2, 1'b0);
        run_op("ovf_bin", 4'h8, 4'h0, 1'b1);

        // Start pulsed mid-operation must be ignored
        @(negedge clk);
        start = 1'b1; x = 4'd9; y = 4'd3; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; done_at = -1; got = '0;
        for (int i = 1; i <= W + 3; i++) begin
            @(negedge clk);
            if (i == 2) begin
                start = 1'b1; x = 4'd1; y = 4'd1; bin = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                done_at = i;
                got = diff;
            end
        end
        start = 1'b0;
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_lat", 32'(done_at), 32'(W));
        chk("ign_diff", 32'(got), 32'h6);
        chk("ign_bout", 32'(bout), 32'd0);
        prev_diff = 4'h6;

        // Asynchronous reset in the middle of SHIFT
        @(negedge clk);
        start = 1'b1; x = 4'd3; y = 4'd9; bin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_bout", 32'(bout), 32'd0);
`ifdef SUB_OVF_EN
        chk("arst_ovf", 32'(ovf), 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("arst_no_done", 32'(ndone), 32'd0);
        prev_diff = '0;
        run_op("post_rst", 4'd5, 4'd2, 1'b0);

        // Start held high: back-to-back operations every W+2 cycles
        start = 1'b1;
        last_done = -1;
        cyc = 0;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!ready && n < 3 * W) begin
                @(posedge clk); #1;
                n++; cyc++;
            end
            chk("b2b_ready_wait", 32'(ready), 32'd1);
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            x = ra; y = rb; bin = rc;
            @(posedge clk); #1;
            cyc++;
            n = 0;
            while (!done && n < 3 * W) begin
                @(posedge clk); #1;
                n++; cyc++;
            end
            chk("b2b_done_seen", 32'(done), 32'd1);
            check_result("b2b", int'(ra), int'(rb), int'(rc));
            if (k > 0) chk("b2b_period", 32'(cyc - last_done), 32'(W + 2));
            last_done = cyc;
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        prev_diff = diff;

        // Random operands against the arithmetic reference
        for (int k = 0; k < 40; k++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
